// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions. Function-code constants and the packed
//               request record that moves a granted operation into the
//               operand stage of alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_ADD  = 4'd0;
    localparam logic [3:0] c_SLL  = 4'd1;
    localparam logic [3:0] c_SLT  = 4'd2;
    localparam logic [3:0] c_SLTU = 4'd3;
    localparam logic [3:0] c_XOR  = 4'd4;
    localparam logic [3:0] c_SRL  = 4'd5;
    localparam logic [3:0] c_OR   = 4'd6;
    localparam logic [3:0] c_AND  = 4'd7;
    localparam logic [3:0] c_SUB  = 4'd8;
    localparam logic [3:0] c_BGE  = 4'd9;
    localparam logic [3:0] c_BGEU = 4'd10;
    localparam logic [3:0] c_SRA  = 4'd13;

    // Tag field is sized for the widest supported tag; narrower tags are
    // zero-extended into it and truncated again on the way out.
    localparam int TAG_MAX_W = 16;

    typedef struct packed {
        logic [3:0]           fn;
        logic [31:0]          a;
        logic [31:0]          b;
        logic                 bneq;
        logic                 btype;
        logic [TAG_MAX_W-1:0] tag;
    } alu_req_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational 32-bit integer ALU with branch-compare output.
//               Unknown function codes produce result 0 and btaken 0.
// Ports       : alu_fn   - function code (alu_pkg constants)
//               operandA - operand A
//               operandB - operand B
//               bneq     - on SUB, branch on not-equal instead of equal
//               btype    - operation is a branch compare (gates btaken)
//               result   - ALU result
//               btaken   - branch condition
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  alu_fn,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        bneq,
    input  logic        btype,
    output logic [31:0] result,
    output logic        btaken
);

    logic w_lt;
    logic w_ltu;
    logic w_ne;

    assign w_lt  = $signed(operandA) < $signed(operandB);
    assign w_ltu = operandA < operandB;
    assign w_ne  = operandA != operandB;

    always_comb begin
        result = '0;
        btaken = 1'b0;
        case (alu_fn)
            c_ADD:  result = operandA + operandB;
            c_SLL:  result = operandA << operandB[4:0];
            c_SLT:  begin result = {31'b0, w_lt};   btaken = btype & w_lt;   end
            c_SLTU: begin result = {31'b0, w_ltu};  btaken = btype & w_ltu;  end
            c_XOR:  result = operandA ^ operandB;
            c_SRL:  result = operandA >> operandB[4:0];
            c_OR:   result = operandA | operandB;
            c_AND:  result = operandA & operandB;
            c_SUB:  begin
                result = operandA - operandB;
                btaken = btype & (bneq ? w_ne : !w_ne);
            end
            c_BGE:  begin result = {31'b0, !w_lt};  btaken = btype & !w_lt;  end
            c_BGEU: begin result = {31'b0, !w_ltu}; btaken = btype & !w_ltu; end
            c_SRA:  result = 32'($signed(operandA) >>> operandB[4:0]);
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr
// Description : Combinational request arbiter. With ALU_ARB_RR_EN defined the
//               search starts at a round-robin pointer that advances to
//               winner+1 on each accepted grant; otherwise the lowest valid
//               index wins and no pointer register exists.
// Macro       : ALU_ARB_RR_EN - enables round-robin arbitration
// Ports       : clk, nrst - clock, asynchronous active-low reset
//               valid     - request valids
//               accept    - the current grant is being taken this edge
//               any       - at least one valid request
//               idx       - index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N_REQ-1:0] valid,
    input  logic             accept,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    assign any = |valid;

`ifdef ALU_ARB_RR_EN
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_d;
    logic [N_REQ-1:0] w_rot;
    logic [ID_W-1:0]  w_off;
    logic [ID_W:0]    w_sum;

    // Rotate so the pointer position sits at bit 0, then take the first set bit.
    assign w_rot = N_REQ'({valid, valid} >> ptr_q);

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = ID_W'(i);
        end
        w_sum = {1'b0, ptr_q} + {1'b0, w_off};
        if (w_sum >= (ID_W + 1)'(N_REQ)) w_sum = w_sum - (ID_W + 1)'(N_REQ);
        idx   = w_sum[ID_W-1:0];
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`else
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, nrst, accept};

    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid[i]) idx = ID_W'(i);
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between N_REQ requesters. Grants one request
//               into a registered operand stage (OP); the ALU evaluates OP
//               combinationally and the result lands in a registered response
//               stage (RS) with a valid/ready handshake. Two-cycle latency,
//               one operation per cycle when the consumer is ready.
// Macro       : ALU_ARB_RR_EN - round-robin grant (else fixed priority)
// Ports       : req_*  - per-requester valid/ready, fn, operands, branch
//                        controls and tag
//               rsp_*  - response valid/ready, requester id, tag, result and
//                        branch-taken
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][3:0]        req_fn,
    input  logic [N_REQ-1:0][31:0]       req_a,
    input  logic [N_REQ-1:0][31:0]       req_b,
    input  logic [N_REQ-1:0]             req_bneq,
    input  logic [N_REQ-1:0]             req_btype,
    input  logic [N_REQ-1:0][TAG_W-1:0]  req_tag,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(N_REQ)-1:0]     rsp_id,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic [31:0]                  rsp_result,
    output logic                         rsp_btaken
);

    localparam int ID_W = $clog2(N_REQ);

    logic            w_any;
    logic [ID_W-1:0] w_idx;
    logic            w_rs_adv;
    logic            w_op_free;
    logic            w_accept;
    alu_req_t        w_sel;
    logic [31:0]     w_alu_result;
    logic            w_alu_btaken;

    logic            op_valid_q,  op_valid_d;
    alu_req_t        op_q,        op_d;
    logic [ID_W-1:0] op_id_q,     op_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rs_result_q, rs_result_d;
    logic            rs_btaken_q, rs_btaken_d;
    logic [TAG_W-1:0] rs_tag_q,   rs_tag_d;
    logic [ID_W-1:0] rs_id_q,     rs_id_d;

    arb_rr #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk    (clk),
        .nrst   (nrst),
        .valid  (req_valid),
        .accept (w_accept),
        .any    (w_any),
        .idx    (w_idx)
    );

    alu u_alu (
        .alu_fn   (op_q.fn),
        .operandA (op_q.a),
        .operandB (op_q.b),
        .bneq     (op_q.bneq),
        .btype    (op_q.btype),
        .result   (w_alu_result),
        .btaken   (w_alu_btaken)
    );

    // Upper tag bits are always zero-extension; only TAG_W of them travel on.
    logic w_unused_tag;
    assign w_unused_tag = ^op_q.tag;

    always_comb begin
        // RS empties or drains this edge; OP can then move on as well.
        w_rs_adv  = !rsp_valid_q || rsp_ready;
        w_op_free = !op_valid_q || w_rs_adv;
        w_accept  = w_op_free && w_any;

        req_ready = '0;
        if (w_accept) req_ready[w_idx] = 1'b1;

        w_sel       = '0;
        w_sel.fn    = req_fn[w_idx];
        w_sel.a     = req_a[w_idx];
        w_sel.b     = req_b[w_idx];
        w_sel.bneq  = req_bneq[w_idx];
        w_sel.btype = req_btype[w_idx];
        w_sel.tag   = TAG_MAX_W'(req_tag[w_idx]);

        op_valid_d = op_valid_q;
        op_d       = op_q;
        op_id_d    = op_id_q;
        if (w_op_free) begin
            op_valid_d = w_accept;
            if (w_accept) begin
                op_d    = w_sel;
                op_id_d = w_idx;
            end
        end

        rsp_valid_d = rsp_valid_q;
        rs_result_d = rs_result_q;
        rs_btaken_d = rs_btaken_q;
        rs_tag_d    = rs_tag_q;
        rs_id_d     = rs_id_q;
        if (w_rs_adv) begin
            rsp_valid_d = op_valid_q;
            if (op_valid_q) begin
                rs_result_d = w_alu_result;
                rs_btaken_d = w_alu_btaken & op_q.btype;
                rs_tag_d    = op_q.tag[TAG_W-1:0];
                rs_id_d     = op_id_q;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op_valid_q  <= 1'b0;
            op_q        <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rs_result_q <= '0;
            rs_btaken_q <= 1'b0;
            rs_tag_q    <= '0;
            rs_id_q     <= '0;
        end else begin
            op_valid_q  <= op_valid_d;
            op_q        <= op_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rs_result_q <= rs_result_d;
            rs_btaken_q <= rs_btaken_d;
            rs_tag_q    <= rs_tag_d;
            rs_id_q     <= rs_id_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rs_id_q;
    assign rsp_tag    = rs_tag_q;
    assign rsp_result = rs_result_q;
    assign rsp_btaken = rs_btaken_q;

endmodule
`default_nettype wire
